l1_instr_ctrl: RTL and testbench
================================

// Module: l1_instr_ctrl
// PURPOSE
//  Fetch-side controller for the L1 instruction cache set (64 rows x 128b, 9b tag, valid bit).
//  Accepts fetch requests from the core and checks tag/valid of the indexed line and of the next line.
//  Refills missing lines from L2 over a valid/ready request/response pair, writes them into the set,
//  then returns one 32b instruction; halfword-aligned fetches straddling a line boundary are supported.
// PARAMETERS
//  block_size  128  line width in bits
//  tag_size    9    tag bits
//  idx_size    6    index bits (64 rows)
//  off_size    4    byte-offset bits (log2(block_size/8))
//  instr_size  32   returned instruction width
// PORTS
//  clk_i              in   1                    clock, rising edge
//  rst_ni             in   1                    reset, asynchronous, active-low
//  fetch_valid_i      in   1                    core fetch request valid
//  fetch_ready_o      out  1                    controller accepts request (IDLE only)
//  fetch_addr_i       in   tag+idx+off (19)     byte address, bit0 ignored
//  fetch_rsp_valid_o  out  1                    instruction valid
//  fetch_rsp_ready_i  in   1                    core accepts instruction
//  fetch_instr_o      out  instr_size           instruction, little-endian
//  cache_tag_idx_o    out  tag+idx (15)         line address to set (tag in upper bits)
//  cache_block_o      out  block_size           refill data to set
//  cache_we_o         out  1                    write row idx with {valid=1,tag}, data
//  cache_we_next_o    out  1                    reserved, constant 0
//  cache_block_i      in   block_size           row idx data (combinational read)
//  cache_valid_i      in   1                    row idx valid
//  cache_tag_i        in   tag_size             row idx tag
//  cache_block_next_i in   16                   low 16b of row (idx+1) mod 64
//  cache_valid_next_i in   1                    row (idx+1) mod 64 valid
//  cache_tag_next_i   in   tag_size             row (idx+1) mod 64 tag
//  l2_req_valid_o     out  1                    line request to L2
//  l2_req_ready_i     in   1                    L2 accepts request
//  l2_req_addr_o      out  tag+idx (15)         requested line address
//  l2_rsp_valid_i     in   1                    L2 line data valid
//  l2_rsp_ready_o     out  1                    controller accepts line
//  l2_rsp_block_i     in   block_size           line data
//  hit_cnt_o          out  16                   lookups completing without refill, wraps
//  miss_cnt_o         out  16                   lines refilled, wraps
// BEHAVIOUR
//  Reset (async, rst_ni=0): state IDLE; all outputs 0 except fetch_ready_o=1; counters 0; captured addr 0.
//  States IDLE, LOOKUP, REQ, WAIT, FILL, RESP; one-hot or binary, unreachable codes -> IDLE.
//  IDLE: fetch_ready_o=1; fetch_valid_i=1 -> capture A=fetch_addr_i, go LOOKUP.
//  LOOKUP: cache_tag_idx_o=A line; hit0 = valid && tag==A.tag.
//    straddle = A.off[3:1]==3'b111; L2 = A line+1 (15b, wraps 0x7FFF->0); hit1 = valid_next && tag_next==L2.tag.
//    hit0 && (!straddle||hit1) -> latch instr, hit_cnt++ only if no refill this request, go RESP.
//    else miss line M = !hit0 ? A line : L2; go REQ (primary line always refilled first).
//  REQ: l2_req_valid_o=1, l2_req_addr_o=M held stable; l2_req_ready_i=1 -> WAIT.
//  WAIT: l2_rsp_ready_o=1; l2_rsp_valid_i=1 -> capture block, go FILL.
//  FILL: cache_tag_idx_o=M, cache_block_o=captured, cache_we_o=1 for exactly one cycle; miss_cnt++; -> LOOKUP.
//  RESP: fetch_rsp_valid_o=1, fetch_instr_o stable until fetch_rsp_ready_i=1 -> IDLE.
//  Instr: off<=12: block[8*off +: 32]; off=14: {block_next[15:0], block[127:112]}.
//  Latency: non-straddle hit -> rsp_valid 2 cycles after accept; each refill adds REQ+WAIT+FILL+LOOKUP (>=4).
//  Straddle miss on both lines: two refills, primary then next; miss_cnt +2, hit_cnt unchanged.
//  Outputs other than current-state strobes held 0; cache_we_o never asserted outside FILL.
//  Reset mid-refill abandons L2 transaction; L2 is reset with the same rst_ni.
// TESTING
//  Cold fetch A=0x00040 -> REQ addr 0x0004, fill row 4, miss_cnt=1, instr=l2 block[31:0].
//  Repeat A=0x00040 -> rsp_valid 2 cycles after accept, no l2_req, hit_cnt=1.
//  A=0x0004E, row 4 hit, row 5 invalid -> one refill of line 0x0005, instr={blk5[15:0],blk4[127:112]}.
//  A=0x7FFFE both lines cold -> refills 0x7FFF then 0x0000 (row 0, tag 0), miss_cnt +2.
//  l2_req_ready_i low 5 cycles, fetch_rsp_ready_i low 3 -> req_addr/instr held stable.
//  rst_ni low during WAIT -> immediate IDLE, no cache_we_o, counters 0.

Source files
------------

// File: rtl/l1_instr_ctrl_if.sv
// Bundle of the fetch, cache-set and L2 signals of the L1 instruction controller.
// master = controller side, slave = core / cache set / L2 side.
interface l1_instr_ctrl_if;
   localparam int unsigned block_size = 128;
   localparam int unsigned tag_size   = 9;
   localparam int unsigned idx_size   = 6;
   localparam int unsigned off_size   = 4;
   localparam int unsigned instr_size = 32;
   localparam int unsigned line_w     = tag_size + idx_size;
   localparam int unsigned addr_w     = line_w + off_size;

   logic                  fetch_valid_i;
   logic                  fetch_ready_o;
   logic [addr_w-1:0]     fetch_addr_i;
   logic                  fetch_rsp_valid_o;
   logic                  fetch_rsp_ready_i;
   logic [instr_size-1:0] fetch_instr_o;
   logic [line_w-1:0]     cache_tag_idx_o;
   logic [block_size-1:0] cache_block_o;
   logic                  cache_we_o;
   logic                  cache_we_next_o;
   logic [block_size-1:0] cache_block_i;
   logic                  cache_valid_i;
   logic [tag_size-1:0]   cache_tag_i;
   logic [15:0]           cache_block_next_i;
   logic                  cache_valid_next_i;
   logic [tag_size-1:0]   cache_tag_next_i;
   logic                  l2_req_valid_o;
   logic                  l2_req_ready_i;
   logic [line_w-1:0]     l2_req_addr_o;
   logic                  l2_rsp_valid_i;
   logic                  l2_rsp_ready_o;
   logic [block_size-1:0] l2_rsp_block_i;
   logic [15:0]           hit_cnt_o;
   logic [15:0]           miss_cnt_o;

   modport master (
      input  fetch_valid_i, fetch_addr_i, fetch_rsp_ready_i,
      input  cache_block_i, cache_valid_i, cache_tag_i,
      input  cache_block_next_i, cache_valid_next_i, cache_tag_next_i,
      input  l2_req_ready_i, l2_rsp_valid_i, l2_rsp_block_i,
      output fetch_ready_o, fetch_rsp_valid_o, fetch_instr_o,
      output cache_tag_idx_o, cache_block_o, cache_we_o, cache_we_next_o,
      output l2_req_valid_o, l2_req_addr_o, l2_rsp_ready_o,
      output hit_cnt_o, miss_cnt_o
   );

   modport slave (
      output fetch_valid_i, fetch_addr_i, fetch_rsp_ready_i,
      output cache_block_i, cache_valid_i, cache_tag_i,
      output cache_block_next_i, cache_valid_next_i, cache_tag_next_i,
      output l2_req_ready_i, l2_rsp_valid_i, l2_rsp_block_i,
      input  fetch_ready_o, fetch_rsp_valid_o, fetch_instr_o,
      input  cache_tag_idx_o, cache_block_o, cache_we_o, cache_we_next_o,
      input  l2_req_valid_o, l2_req_addr_o, l2_rsp_ready_o,
      input  hit_cnt_o, miss_cnt_o
   );
endinterface

// File: rtl/l1_instr_ctrl.sv
// Fetch-side controller for the L1 instruction cache set: tag lookup of the
// indexed and next line, L2 refill of missing lines, one 32b instruction per fetch.
module l1_instr_ctrl (
   input logic             clk_i,
   input logic             rst_ni,
   l1_instr_ctrl_if.master bus
);
   localparam int unsigned block_size = 128;
   localparam int unsigned tag_size   = 9;
   localparam int unsigned idx_size   = 6;
   localparam int unsigned off_size   = 4;
   localparam int unsigned instr_size = 32;
   localparam int unsigned line_w     = tag_size + idx_size;
   localparam int unsigned addr_w     = line_w + off_size;
   localparam int unsigned ext_w      = block_size + 16;

   typedef enum logic [2:0] {IDLE, LOOKUP, REQ, WAIT, FILL, RESP} state_t;

   state_t              state;
   logic [addr_w-1:0]   addr_q;
   logic [line_w-1:0]   miss_line_q;
   logic                refilled_q;

   logic [line_w-1:0]   a_line;
   logic [line_w-1:0]   next_line;
   logic [line_w-1:0]   miss_line;
   logic                straddle;
   logic                hit0;
   logic                hit1;
   logic                look_hit;
   logic [ext_w-1:0]    ext;
   logic [instr_size-1:0] instr;

   // Lookup decode: the next line only matters for a fetch in the last halfword.
   always_comb begin
      a_line    = addr_q[addr_w-1:off_size];
      next_line = a_line + line_w'(1);
      straddle  = (addr_q[off_size-1:1] == 3'b111);
      hit0      = bus.cache_valid_i && (bus.cache_tag_i == a_line[line_w-1:idx_size]);
      hit1      = bus.cache_valid_next_i && (bus.cache_tag_next_i == next_line[line_w-1:idx_size]);
      look_hit  = hit0 && (!straddle || hit1);
      miss_line = hit0 ? next_line : a_line;
      ext       = {bus.cache_block_next_i, bus.cache_block_i} >> {addr_q[off_size-1:1], 4'b0000};
      instr     = ext[instr_size-1:0];
   end

   assign bus.cache_we_next_o = 1'b0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state                 <= IDLE;
         addr_q                <= '0;
         miss_line_q           <= '0;
         refilled_q            <= 1'b0;
         bus.fetch_ready_o     <= 1'b1;
         bus.fetch_rsp_valid_o <= 1'b0;
         bus.fetch_instr_o     <= '0;
         bus.cache_tag_idx_o   <= '0;
         bus.cache_block_o     <= '0;
         bus.cache_we_o        <= 1'b0;
         bus.l2_req_valid_o    <= 1'b0;
         bus.l2_req_addr_o     <= '0;
         bus.l2_rsp_ready_o    <= 1'b0;
         bus.hit_cnt_o         <= '0;
         bus.miss_cnt_o        <= '0;
      end else begin
         bus.cache_we_o <= 1'b0;
         case (state)
            IDLE: if (bus.fetch_valid_i) begin
               addr_q              <= bus.fetch_addr_i;
               bus.cache_tag_idx_o <= bus.fetch_addr_i[addr_w-1:off_size];
               bus.fetch_ready_o   <= 1'b0;
               refilled_q          <= 1'b0;
               state               <= LOOKUP;
            end
            LOOKUP: begin
               bus.cache_tag_idx_o <= '0;
               if (look_hit) begin
                  bus.fetch_instr_o     <= instr;
                  bus.fetch_rsp_valid_o <= 1'b1;
                  if (!refilled_q) bus.hit_cnt_o <= bus.hit_cnt_o + 16'd1;
                  state                 <= RESP;
               end else begin
                  // Primary line is refilled first; the next line on a later pass.
                  miss_line_q        <= miss_line;
                  bus.l2_req_addr_o  <= miss_line;
                  bus.l2_req_valid_o <= 1'b1;
                  refilled_q         <= 1'b1;
                  state              <= REQ;
               end
            end
            REQ: if (bus.l2_req_ready_i) begin
               bus.l2_req_valid_o <= 1'b0;
               bus.l2_req_addr_o  <= '0;
               bus.l2_rsp_ready_o <= 1'b1;
               state              <= WAIT;
            end
            WAIT: if (bus.l2_rsp_valid_i) begin
               bus.l2_rsp_ready_o  <= 1'b0;
               bus.cache_block_o   <= bus.l2_rsp_block_i;
               bus.cache_tag_idx_o <= miss_line_q;
               bus.cache_we_o      <= 1'b1;
               state               <= FILL;
            end
            FILL: begin
               bus.cache_block_o   <= '0;
               bus.cache_tag_idx_o <= addr_q[addr_w-1:off_size];
               bus.miss_cnt_o      <= bus.miss_cnt_o + 16'd1;
               state               <= LOOKUP;
            end
            RESP: if (bus.fetch_rsp_ready_i) begin
               bus.fetch_rsp_valid_o <= 1'b0;
               bus.fetch_instr_o     <= '0;
               bus.fetch_ready_o     <= 1'b1;
               state                 <= IDLE;
            end
            default: begin
               state                 <= IDLE;
               bus.fetch_ready_o     <= 1'b1;
               bus.fetch_rsp_valid_o <= 1'b0;
               bus.fetch_instr_o     <= '0;
               bus.cache_tag_idx_o   <= '0;
               bus.cache_block_o     <= '0;
               bus.l2_req_valid_o    <= 1'b0;
               bus.l2_req_addr_o     <= '0;
               bus.l2_rsp_ready_o    <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_l1_instr_ctrl.sv
// Bench for l1_instr_ctrl: cache-set and L2 models, table of fetches with an
// instruction scoreboard, plus a reset-during-refill sequence.
module tb_l1_instr_ctrl;
   logic clk_i = 1'b0;
   logic rst_ni;
   always #5 clk_i = ~clk_i;

   l1_instr_ctrl_if bus ();
   l1_instr_ctrl dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

   typedef struct {
      logic [18:0] addr;
      int          nreq;
      logic [14:0] l0;
      logic [14:0] l1;
      logic [15:0] hit;
      logic [15:0] miss;
      int          req_hold;
      int          rsp_hold;
   } vec_t;

   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] sb[$];
   logic [14:0] l2q[$];

   // Cache set model: combinational read, written on cache_we_o.
   logic        mdl_init;
   logic        cvalid[64];
   logic [8:0]  ctag[64];
   logic [127:0] cdata[64];
   logic [5:0]  ridx, nidx;
   logic [127:0] nblk;
   assign ridx = bus.cache_tag_idx_o[5:0];
   assign nidx = ridx + 6'd1;
   assign nblk = cdata[nidx];
   assign bus.cache_block_i      = cdata[ridx];
   assign bus.cache_valid_i      = cvalid[ridx];
   assign bus.cache_tag_i        = ctag[ridx];
   assign bus.cache_block_next_i = nblk[15:0];
   assign bus.cache_valid_next_i = cvalid[nidx];
   assign bus.cache_tag_next_i   = ctag[nidx];

   always @(posedge clk_i) begin
      if (mdl_init) begin
         for (int i = 0; i < 64; i++) begin
            cvalid[i] <= 1'b0;
            ctag[i]   <= '0;
            cdata[i]  <= '0;
         end
      end else if (bus.cache_we_o) begin
         cvalid[ridx] <= 1'b1;
         ctag[ridx]   <= bus.cache_tag_idx_o[14:6];
         cdata[ridx]  <= bus.cache_block_o;
      end
   end

   function automatic logic [127:0] blk(input logic [14:0] line);
      logic [127:0] r;
      for (int w = 0; w < 4; w++)
         r[32*w +: 32] = (32'h9E3779B9 * (32'(line) * 32'd4 + 32'(w) + 32'd1)) ^ 32'h5A5A0000;
      return r;
   endfunction

   // Reference instruction: four consecutive bytes of the L2 image, bit0 cleared.
   function automatic logic [31:0] ref_instr(input logic [18:0] a);
      logic [31:0]  r;
      logic [18:0]  b;
      logic [127:0] bv;
      for (int k = 0; k < 4; k++) begin
         b  = {a[18:1], 1'b0} + 19'(k);
         bv = blk(b[18:4]);
         r[8*k +: 8] = bv[8*b[3:0] +: 8];
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   task automatic do_fetch(input vec_t v, input int id);
      int cyc, nreq_seen, nfill, req_wait, rsp_wait;
      logic done;
      logic [14:0] held_addr, cur_line;
      logic [31:0] held_instr;
      cyc = 1; nreq_seen = 0; nfill = 0; req_wait = 0; rsp_wait = 0; done = 1'b0;
      held_addr = '0; cur_line = '0; held_instr = '0;
      @(negedge clk_i);
      chk($sformatf("v%0d fetch_ready", id), 128'(bus.fetch_ready_o), 128'(1'b1));
      bus.fetch_valid_i = 1'b1;
      bus.fetch_addr_i  = v.addr;
      sb.push_back(ref_instr(v.addr));
      if (v.nreq >= 1) l2q.push_back(v.l0);
      if (v.nreq >= 2) l2q.push_back(v.l1);
      @(negedge clk_i);
      bus.fetch_valid_i = 1'b0;
      while (!done && cyc < 200) begin
         if (bus.l2_req_valid_o) begin
            if (req_wait == 0) begin
               nreq_seen++;
               held_addr = bus.l2_req_addr_o;
               if (nreq_seen == 1) chk($sformatf("v%0d miss_latency", id), 128'(cyc), 128'(2));
               if (l2q.size() == 0) fail($sformatf("v%0d unexpected l2_req %0h", id, held_addr));
               else begin
                  cur_line = l2q.pop_front();
                  chk($sformatf("v%0d l2_req_addr", id), 128'(held_addr), 128'(cur_line));
               end
            end else
               chk($sformatf("v%0d l2_req_addr_stable", id), 128'(bus.l2_req_addr_o), 128'(held_addr));
            bus.l2_req_ready_i = (req_wait >= v.req_hold);
            req_wait++;
         end else begin
            bus.l2_req_ready_i = 1'b0;
            req_wait = 0;
         end
         bus.l2_rsp_valid_i = bus.l2_rsp_ready_o;
         bus.l2_rsp_block_i = bus.l2_rsp_ready_o ? blk(cur_line) : '0;
         if (bus.cache_we_o) begin
            nfill++;
            chk($sformatf("v%0d fill_line", id), 128'(bus.cache_tag_idx_o), 128'(cur_line));
            chk($sformatf("v%0d fill_block", id), bus.cache_block_o, blk(cur_line));
         end
         if (bus.fetch_rsp_valid_o) begin
            if (rsp_wait == 0) begin
               held_instr = bus.fetch_instr_o;
               if (v.nreq == 0) chk($sformatf("v%0d hit_latency", id), 128'(cyc), 128'(2));
            end else
               chk($sformatf("v%0d instr_stable", id), 128'(bus.fetch_instr_o), 128'(held_instr));
            if (rsp_wait >= v.rsp_hold) begin
               bus.fetch_rsp_ready_i = 1'b1;
               if (sb.size() == 0) fail($sformatf("v%0d scoreboard empty", id));
               else chk($sformatf("v%0d instr", id), 128'(bus.fetch_instr_o), 128'(sb.pop_front()));
               done = 1'b1;
            end
            rsp_wait++;
         end
         @(negedge clk_i);
         cyc++;
      end
      if (!done) fail($sformatf("v%0d timeout waiting for fetch response", id));
      bus.fetch_rsp_ready_i = 1'b0;
      bus.l2_req_ready_i    = 1'b0;
      bus.l2_rsp_valid_i    = 1'b0;
      chk($sformatf("v%0d rsp_valid_drop", id), 128'(bus.fetch_rsp_valid_o), 128'(1'b0));
      chk($sformatf("v%0d refills", id), 128'(nreq_seen), 128'(v.nreq));
      chk($sformatf("v%0d fills", id), 128'(nfill), 128'(v.nreq));
      chk($sformatf("v%0d hit_cnt", id), 128'(bus.hit_cnt_o), 128'(v.hit));
      chk($sformatf("v%0d miss_cnt", id), 128'(bus.miss_cnt_o), 128'(v.miss));
      chk($sformatf("v%0d l2_left", id), 128'(l2q.size()), 128'(0));
      l2q.delete();
   endtask

   vec_t tbl[11];
   vec_t post;

   initial begin
      rst_ni = 1'b0;
      mdl_init = 1'b1;
      bus.fetch_valid_i = 1'b0;
      bus.fetch_addr_i = '0;
      bus.fetch_rsp_ready_i = 1'b0;
      bus.l2_req_ready_i = 1'b0;
      bus.l2_rsp_valid_i = 1'b0;
      bus.l2_rsp_block_i = '0;

      //           addr      nreq l0        l1       hit     miss  rqh rsh
      tbl[0]  = '{19'h00040, 1, 15'h0004, 15'h0000, 16'd0, 16'd1, 0, 0};
      tbl[1]  = '{19'h00040, 0, 15'h0000, 15'h0000, 16'd1, 16'd1, 0, 0};
      tbl[2]  = '{19'h0004E, 1, 15'h0005, 15'h0000, 16'd1, 16'd2, 5, 3};
      tbl[3]  = '{19'h7FFFE, 2, 15'h7FFF, 15'h0000, 16'd1, 16'd4, 1, 0};
      tbl[4]  = '{19'h00046, 0, 15'h0000, 15'h0000, 16'd2, 16'd4, 0, 2};
      tbl[5]  = '{19'h0005E, 1, 15'h0006, 15'h0000, 16'd2, 16'd5, 0, 0};
      tbl[6]  = '{19'h10040, 1, 15'h1004, 15'h0000, 16'd2, 16'd6, 2, 0};
      tbl[7]  = '{19'h0004C, 1, 15'h0004, 15'h0000, 16'd2, 16'd7, 0, 1};
      tbl[8]  = '{19'h0004F, 0, 15'h0000, 15'h0000, 16'd3, 16'd7, 0, 0};
      tbl[9]  = '{19'h00002, 0, 15'h0000, 15'h0000, 16'd4, 16'd7, 0, 0};
      tbl[10] = '{19'h0003E, 1, 15'h0003, 15'h0000, 16'd4, 16'd8, 0, 0};

      repeat (3) @(negedge clk_i);
      chk("rst fetch_ready", 128'(bus.fetch_ready_o), 128'(1'b1));
      chk("rst rsp_valid", 128'(bus.fetch_rsp_valid_o), 128'(1'b0));
      chk("rst l2_req_valid", 128'(bus.l2_req_valid_o), 128'(1'b0));
      chk("rst l2_rsp_ready", 128'(bus.l2_rsp_ready_o), 128'(1'b0));
      chk("rst cache_we", 128'(bus.cache_we_o), 128'(1'b0));
      chk("rst cache_we_next", 128'(bus.cache_we_next_o), 128'(1'b0));
      chk("rst tag_idx", 128'(bus.cache_tag_idx_o), 128'(0));
      chk("rst hit_cnt", 128'(bus.hit_cnt_o), 128'(0));
      chk("rst miss_cnt", 128'(bus.miss_cnt_o), 128'(0));
      rst_ni = 1'b1;
      mdl_init = 1'b0;

      for (int i = 0; i < 11; i++) do_fetch(tbl[i], i);
      chk("scoreboard drained", 128'(sb.size()), 128'(0));

      // Reset while waiting on the L2 response for a cold line (row 8).
      @(negedge clk_i);
      bus.fetch_valid_i = 1'b1;
      bus.fetch_addr_i  = 19'h20080;
      @(negedge clk_i);
      bus.fetch_valid_i = 1'b0;
      for (int c = 0; c < 20 && !bus.l2_rsp_ready_o; c++) begin
         bus.l2_req_ready_i = bus.l2_req_valid_o;
         @(negedge clk_i);
      end
      bus.l2_req_ready_i = 1'b0;
      if (!bus.l2_rsp_ready_o) fail("reset seq: WAIT not reached");
      chk("wait req_addr cleared", 128'(bus.l2_req_valid_o), 128'(1'b0));
      rst_ni = 1'b0;
      #1;
      chk("async rst fetch_ready", 128'(bus.fetch_ready_o), 128'(1'b1));
      chk("async rst l2_rsp_ready", 128'(bus.l2_rsp_ready_o), 128'(1'b0));
      chk("async rst hit_cnt", 128'(bus.hit_cnt_o), 128'(0));
      chk("async rst miss_cnt", 128'(bus.miss_cnt_o), 128'(0));
      for (int c = 0; c < 2; c++) begin
         @(negedge clk_i);
         chk("rst no cache_we", 128'(bus.cache_we_o), 128'(1'b0));
      end
      rst_ni = 1'b1;
      chk("row8 not filled", 128'(cvalid[8]), 128'(1'b0));

      post = '{19'h00040, 0, 15'h0000, 15'h0000, 16'd1, 16'd0, 0, 0};
      do_fetch(post, 99);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
